uart_rx_ctrl: RTL and testbench

- Sequencing controller for the UART receive datapath.
- Detects the start bit and validates it at mid-bit.
- Enables the baud generator and the 9-tick RX bit counter (8 data + stop), and shifts in sampled bits.
- On the counter's done pulse, checks the stop bit and presents the byte on a valid/ready handshake with frame, overrun and timeout error flags.
- Sits between the rx pin synchronizer and the receive FIFO; the bit counter and baud generator are sibling blocks wired at the UART top.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/rx_sync.sv | 23 ++
 rtl/uart_rx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and frame constants for the UART receive controller.
package uart_rx_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_TICKS = 9;
  localparam int SHREG_W     = FRAME_TICKS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle-high level.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic synced
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], line};
    end
  end

  assign synced = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, bit shifting, stop check,
// valid/ready byte output with frame/overrun/timeout error pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_TIMEOUT = 8192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 baud_tick_rx,
  input  logic                 done_rx,
  output logic                 baud_en,
  output logic                 cnt_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 timeout_err,
  output logic                 busy
);

  // Handshake: a byte transfers on any rising clk edge where rx_valid && rx_ready;
  // rx_data holds steady while rx_valid && !rx_ready.

  localparam int WD_W     = $clog2(TICK_TIMEOUT + 1);
  localparam int STOP_IDX = FRAME_TICKS - 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TICK_TIMEOUT - 1);

  logic rx_s;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line   (rx_in),
    .synced (rx_s)
  );

  rx_state_t            state, state_nxt;
  logic [SHREG_W-1:0]   shreg, shreg_nxt, frame_bits;
  logic [WD_W-1:0]      wd, wd_nxt;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 baud_en_nxt, cnt_en_nxt, rx_valid_nxt, busy_nxt;
  logic                 frame_err_nxt, overrun_err_nxt, timeout_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      wd          <= '0;
      baud_en     <= 1'b0;
      cnt_en      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      wd          <= wd_nxt;
      baud_en     <= baud_en_nxt;
      cnt_en      <= cnt_en_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      frame_err   <= frame_err_nxt;
      overrun_err <= overrun_err_nxt;
      timeout_err <= timeout_err_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    shreg_nxt       = shreg;
    frame_bits      = shreg;
    wd_nxt          = wd;
    baud_en_nxt     = baud_en;
    cnt_en_nxt      = cnt_en;
    rx_data_nxt     = rx_data;
    rx_valid_nxt    = rx_valid && !rx_ready;
    frame_err_nxt   = 1'b0;
    overrun_err_nxt = 1'b0;
    timeout_err_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        wd_nxt = '0;
        if (!rx_s) begin
          state_nxt   = ST_START;
          baud_en_nxt = 1'b1;
          shreg_nxt   = '0;
        end
      end
      ST_START: begin
        if (baud_tick_rx) begin
          wd_nxt = '0;
          if (!rx_s) begin
            state_nxt  = ST_DATA;
            cnt_en_nxt = 1'b1;
          end else begin
            state_nxt   = ST_IDLE;
            baud_en_nxt = 1'b0;
          end
        end else if (wd == WD_LAST) begin
          state_nxt       = ST_IDLE;
          baud_en_nxt     = 1'b0;
          cnt_en_nxt      = 1'b0;
          wd_nxt          = '0;
          timeout_err_nxt = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick_rx) begin
          frame_bits = {rx_s, shreg[SHREG_W-1:1]};
          wd_nxt     = '0;
        end else begin
          wd_nxt = wd + 1'b1;
        end
        shreg_nxt = frame_bits;
        // A tick coincident with done has already been folded into frame_bits.
        if (done_rx) begin
          cnt_en_nxt  = 1'b0;
          baud_en_nxt = 1'b0;
          wd_nxt      = '0;
          if (frame_bits[STOP_IDX]) begin
            state_nxt = ST_IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data_nxt  = frame_bits[DATA_BITS-1:0];
              rx_valid_nxt = 1'b1;
            end else begin
              overrun_err_nxt = 1'b1;
            end
          end else begin
            state_nxt     = ST_BREAK;
            frame_err_nxt = 1'b1;
          end
        end else if (!baud_tick_rx && wd == WD_LAST) begin
          state_nxt       = ST_IDLE;
          baud_en_nxt     = 1'b0;
          cnt_en_nxt      = 1'b0;
          wd_nxt          = '0;
          timeout_err_nxt = 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Disabling the receiver aborts silently but leaves a pending byte alone.
    if (!rx_enable) begin
      state_nxt       = ST_IDLE;
      baud_en_nxt     = 1'b0;
      cnt_en_nxt      = 1'b0;
      shreg_nxt       = '0;
      wd_nxt          = '0;
      rx_data_nxt     = rx_data;
      rx_valid_nxt    = rx_valid && !rx_ready;
      frame_err_nxt   = 1'b0;
      overrun_err_nxt = 1'b0;
      timeout_err_nxt = 1'b0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with behavioural baud generator and bit counter models,
// expected-byte and expected-error queues checked by an independent monitor.
module tb_uart_rx_ctrl;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_enable = 1'b0;
  logic       rx_in = 1'b1;
  logic       baud_tick_rx = 1'b0;
  logic       done_rx = 1'b0;
  logic       rx_ready = 1'b1;
  logic       baud_en, cnt_en, rx_valid, frame_err, overrun_err, timeout_err, busy;
  logic [7:0] rx_data;
  logic       tick_stop = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];  // 1 frame, 2 overrun, 3 timeout

  always #5 clk = ~clk;

  uart_rx_ctrl #(.SYNC_STAGES(2), .TICK_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_enable    (rx_enable),
    .rx_in        (rx_in),
    .baud_tick_rx (baud_tick_rx),
    .done_rx      (done_rx),
    .baud_en      (baud_en),
    .cnt_en       (cnt_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Baud generator and bit counter models, updated on the falling edge.
  initial begin : models
    int   bcnt;
    int   ccnt;
    logic cnt_en_last;
    bcnt = 0;
    ccnt = 0;
    cnt_en_last = 1'b0;
    forever begin
      @(negedge clk);
      done_rx = 1'b0;
      if (baud_tick_rx && cnt_en_last) begin
        ccnt++;
        if (ccnt == 9) begin
          done_rx = 1'b1;
          ccnt = 0;
        end
      end
      if (!cnt_en) ccnt = 0;
      cnt_en_last = cnt_en;
      if (!baud_en) bcnt = 0;
      else bcnt++;
      baud_tick_rx = baud_en && !tick_stop && (bcnt >= HALF) && (((bcnt - HALF) % BIT) == 0);
    end
  end

  // Monitor: pops expected bytes on accepted transfers and expected errors on pulses.
  initial begin : monitor
    logic       prev_valid;
    logic       prev_done;
    logic [2:0] prev_errs;
    logic [2:0] errs;
    logic [1:0] code;
    prev_valid = 1'b0;
    prev_done  = 1'b0;
    prev_errs  = 3'b0;
    forever begin
      @(negedge clk);
      #2;
      errs = {frame_err, overrun_err, timeout_err};
      if (rx_valid && !prev_valid) begin
        check("valid_latency_after_done", 32'(prev_done), 32'd1);
        check("enables_low_at_load", 32'({baud_en, cnt_en}), 32'd0);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (prev_errs != 3'b0) check("err_pulse_width", 32'(errs & prev_errs), 32'd0);
      if (errs != 3'b0) begin
        code = frame_err ? 2'd1 : (overrun_err ? 2'd2 : 2'd3);
        if (err_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_error: got code %0d, expected none", code);
        end else begin
          check("err_kind", 32'(code), 32'(err_q.pop_front()));
        end
      end
      prev_valid = rx_valid;
      prev_done  = done_rx;
      prev_errs  = errs;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      idle(BIT);
    end
    rx_in = stop;
    idle(BIT);
  endtask

  task automatic ready_on_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_rx) begin
        rx_ready = 1'b1;
        seen = 1'b1;
      end
    end
    check("done_seen_frame_33", 32'(seen), 32'd1);
  endtask

  initial begin : global_limit
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int  k;
    bit  hit;

    idle(3);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_enables", 32'({baud_en, cnt_en}), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    idle(4);

    // Good frame 0xA5 with consumer ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(6);
    check("a5_valid_consumed", 32'(rx_valid), 32'd0);
    check("a5_idle", 32'(busy), 32'd0);

    // Short low glitch on the line.
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(3);
    check("glitch_start_baud_en", 32'(baud_en), 32'd1);
    idle(10);
    check("glitch_baud_en_drop", 32'(baud_en), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Frame 0x3C with a bad stop bit, line held low for 3 bit times.
    err_q.push_back(2'd1);
    send_frame(8'h3C, 1'b0);
    idle(3 * BIT);
    check("break_busy", 32'(busy), 32'd1);
    check("break_no_valid", 32'(rx_valid), 32'd0);
    rx_in = 1'b1;
    idle(6);
    check("break_exit_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(6);

    // Overrun: 0x11 held, 0x22 dropped, 0x33 loaded on the accept edge.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(6);
    check("hold_valid_11", 32'(rx_valid), 32'd1);
    check("hold_data_11", 32'(rx_data), 32'h11);
    err_q.push_back(2'd2);
    send_frame(8'h22, 1'b1);
    idle(6);
    check("overrun_keeps_11", 32'(rx_data), 32'h11);
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      ready_on_done();
    join
    idle(6);
    check("after_33_valid_clear", 32'(rx_valid), 32'd0);
    check("after_33_data", 32'(rx_data), 32'h33);

    // Watchdog: stop ticks mid-DATA.
    rx_in = 1'b0;
    idle(BIT);
    rx_in = 1'b1;
    idle(30);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (baud_tick_rx) hit = 1'b1;
    end
    check("tick_seen_before_stop", 32'(hit), 32'd1);
    check("timeout_in_data", 32'(cnt_en), 32'd1);
    tick_stop = 1'b1;
    err_q.push_back(2'd3);
    k = 0;
    hit = 1'b0;
    for (int i = 1; i <= 200 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (timeout_err) begin
        hit = 1'b1;
        k = i;
      end
    end
    check("timeout_latency", 32'(k), 32'd65);
    check("timeout_idle", 32'({busy, baud_en, cnt_en}), 32'd0);
    tick_stop = 1'b0;
    idle(4);

    // rx_enable dropped mid-frame.
    rx_in = 1'b0;
    idle(BIT);
    rx_in = 1'b1;
    idle(40);
    check("enable_test_in_data", 32'(cnt_en), 32'd1);
    rx_enable = 1'b0;
    @(negedge clk);
    #2;
    check("disable_idle", 32'({busy, baud_en, cnt_en}), 32'd0);
    idle(4);
    rx_enable = 1'b1;
    idle(4);

    // Asynchronous reset during DATA, then a clean 0xFF frame.
    rx_in = 1'b0;
    idle(BIT);
    rx_in = 1'b1;
    idle(40);
    check("reset_test_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({busy, baud_en, cnt_en, rx_valid}), 32'd0);
    check("async_reset_data", 32'(rx_data), 32'd0);
    check("async_reset_errs", 32'({frame_err, overrun_err, timeout_err}), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    idle(10);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
